// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared FSM type, register offsets and source priority encoder for int_ctrl.
package int_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_e;
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_VBASE = 2'd2;
  localparam logic [2:0] SPURIOUS_IDX = 3'b111;
  // {found, idx}: lowest set bit wins; idx is SPURIOUS_IDX when nothing is set
  function automatic logic [3:0] prio_enc(input logic [7:0] v);
    prio_enc = {1'b0, SPURIOUS_IDX};
    for (int i = 7; i >= 0; i--)
      if (v[i]) prio_enc = {1'b1, 3'(i)};
  endfunction
endpackage

// File: rtl/rise_det.sv
// rise_det: registered rising-edge detector; the first cycle after reset never reports an edge.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic prev_q, armed_q, rise_q, rise_d;
  always_comb rise_d = d & ~prev_q & armed_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      prev_q  <= d;
      armed_q <= 1'b1;
      rise_q  <= rise_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: prioritised interrupt controller with MASK/PEND/VBASE IO registers and vectored acknowledge.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter logic [7:0] BASE_PORT = 8'h10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [7:0]         addr,
  input  logic               iord,
  input  logic               iowr,
  input  logic               inta,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               dout_en,
  output logic               int_n
);
  logic rd_rise, wr_rise, ack_rise;
  logic [NUM_SRC-1:0] irq_rise;
  rise_det u_rd  (.clk(clk), .rst_n(rst_n), .d(iord), .rise(rd_rise));
  rise_det u_wr  (.clk(clk), .rst_n(rst_n), .d(iowr), .rise(wr_rise));
  rise_det u_ack (.clk(clk), .rst_n(rst_n), .d(inta), .rise(ack_rise));
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_irq
    rise_det u_det (.clk(clk), .rst_n(rst_n), .d(irq[i]), .rise(irq_rise[i]));
  end
  state_e state_q, state_d;
  logic [NUM_SRC-1:0] mask_q, mask_d, pend_q, pend_d, wr_clr, ack_clr;
  logic [3:0] vbase_q, vbase_d, win;
  logic [7:0] vec_q, vec_d, off, rd_data;
  logic rd_en_q, rd_en_d, int_n_q, int_n_d, mapped, wr_hit, vec_out;
  always_comb begin
    off     = addr - BASE_PORT;
    mapped  = off < 8'd3;
    wr_hit  = wr_rise & mapped;
    win     = prio_enc(8'(pend_q & mask_q));
    rd_data = off[1:0] == REG_MASK ? 8'(mask_q) : off[1:0] == REG_PEND ? 8'(pend_q) : {vbase_q, 4'h0};
    mask_d  = (wr_hit && off[1:0] == REG_MASK) ? din[NUM_SRC-1:0] : mask_q;
    vbase_d = (wr_hit && off[1:0] == REG_VBASE) ? din[7:4] : vbase_q;
    wr_clr  = (wr_hit && off[1:0] == REG_PEND) ? din[NUM_SRC-1:0] : '0;
    rd_en_d = iord & mapped & (rd_en_q | rd_rise);
    state_d = state_q;
    vec_d   = vec_q;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        state_d = ack_rise ? ACK : win[3] ? REQ : IDLE;
        vec_d   = ack_rise ? {vbase_q, SPURIOUS_IDX, 1'b0} : vec_q;
      end
      REQ: begin
        state_d = ack_rise ? ACK : win[3] ? REQ : IDLE;
        vec_d   = ack_rise ? {vbase_q, win[2:0], 1'b0} : vec_q;
        ack_clr = (ack_rise && win[3]) ? NUM_SRC'(1) << win[2:0] : '0;
      end
      ACK:  state_d = HOLD;
      HOLD: state_d = inta ? HOLD : IDLE;
    endcase
    // a coincident irq edge beats both the acknowledge clear and a software clear
    pend_d  = (pend_q & ~wr_clr & ~ack_clr) | irq_rise;
    int_n_d = state_d != REQ;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      vbase_q <= '0;
      vec_q   <= '0;
      rd_en_q <= 1'b0;
      int_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      vbase_q <= vbase_d;
      vec_q   <= vec_d;
      rd_en_q <= rd_en_d;
      int_n_q <= int_n_d;
    end
  end
  assign vec_out = state_q == ACK || state_q == HOLD;
  assign dout_en = vec_out | rd_en_q;
  assign dout    = vec_out ? vec_q : rd_en_q ? rd_data : 8'h00;
  assign int_n   = int_n_q;
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 4: number of interrupt sources, legal range 1..8.
REQ-002 Parameter BASE_PORT, default 8'h10: IO address of register 0. Registers occupy BASE_PORT..BASE_PORT+2.
REQ-003 clk  input  1: single system clock. All logic is rising-edge on clk.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 irq  input  NUM_SRC: interrupt requests, synchronous to clk; a rising edge requests service.
REQ-006 addr  input  8: low byte of the CPU address bus.
REQ-007 iord  input  1: decoded IO read, level.
REQ-008 iowr  input  1: decoded IO write, level.
REQ-009 inta  input  1: decoded interrupt acknowledge (~m1_n & ~iorq_n), level.
REQ-010 din  input  8: CPU data bus in.
REQ-011 dout  output  8: read data or interrupt vector.
REQ-012 dout_en  output  1: high when dout is to be driven onto the CPU data bus.
REQ-013 int_n  output  1: active-low interrupt request to the CPU, registered.

Function
REQ-014 Register map:
- BASE_PORT+0 MASK (R/W): 1 = source enabled.
- BASE_PORT+1 PEND (R; write 1 clears that bit).
- BASE_PORT+2 VBASE (R/W): only bits 7:4 are stored; bits 3:0 read as 0.
REQ-015 iowr, iord and inta are acted on once per assertion, on the cycle after their registered rising edge is detected. Edge detection adds 1 cycle of latency.
REQ-016 A write updates the addressed register 1 cycle after the iowr edge. Writes to unmapped addresses are ignored.
REQ-017 dout_en and dout:
- During iord high with a mapped addr, dout_en=1 and dout=register content, starting 1 cycle after the edge.
- dout_en falls in the cycle after iord falls.
- Unmapped addresses keep dout_en=0.
REQ-018 An irq rising edge sets PEND[i] 2 cycles after the edge (sync + detect). Masked sources still set PEND.
REQ-019 If an irq set and a PEND write-1-clear hit the same bit in the same cycle, the set wins.
REQ-020 FSM states: IDLE, REQ, ACK, HOLD.
REQ-021 IDLE -> REQ when (PEND & MASK) != 0. In REQ, int_n=0; otherwise int_n=1.
REQ-022 REQ -> IDLE if (PEND & MASK) becomes 0 before acknowledge; int_n returns to 1 the next cycle.
REQ-023 REQ -> ACK on the inta edge. The ACK cycle does the following:
- Latches the winner: the lowest-index set bit of PEND & MASK (source 0 has highest priority).
- Clears that PEND bit.
- Sets vector = {VBASE[7:4], idx[2:0], 1'b0}.
REQ-024 If no enabled source is pending at the inta edge, the vector is spurious: {VBASE[7:4], 3'b111, 1'b0}, and no PEND bit changes. With NUM_SRC=8, index 7 and spurious vectors are identical; software distinguishes them via PEND.
REQ-025 ACK -> HOLD next cycle. In ACK and HOLD: dout=vector, dout_en=1, int_n=1.
REQ-026 HOLD -> IDLE in the cycle after inta is low. dout_en=0 from that IDLE cycle.
REQ-027 inta edges seen in IDLE produce the spurious vector through ACK/HOLD; no pending bits change.
REQ-028 An iowr edge coincident with the ACK cycle is applied. The PEND update uses the ACK clear OR the write clear, with irq sets still winning.

Reset
REQ-029 While rst_n=0: MASK=0, PEND=0, VBASE=0, FSM=IDLE, int_n=1, dout=8'h00, dout_en=0, and all edge-detect history registers=0.
REQ-030 Reset asserted mid-acknowledge aborts immediately to the reset values. After release, a still-high inta or irq level is not treated as a new edge.

Structure
REQ-031 Package int_ctrl_pkg holds the following:
- the FSM state enum;
- register offsets REG_MASK=0, REG_PEND=1, REG_VBASE=2;
- SPURIOUS_IDX=3'b111.
REQ-032 Sub-module rise_det (1-bit, registered rising-edge detector with async active-low reset) is instantiated once each for iord, iowr, inta and each irq bit.
REQ-033 Priority encoding is a function in int_ctrl_pkg. There are no other sub-modules.

Verification
REQ-034 Write MASK=8'h0F, VBASE=8'h40; pulse irq[2]. Required: int_n=0 three cycles after the irq edge. On inta: dout=8'h44, dout_en=1, PEND[2]=0.
REQ-035 irq[1] and irq[3] rise in the same cycle, MASK=8'h0F, VBASE=8'h40. Required: first ack returns 8'h42 and int_n re-asserts; second ack returns 8'h46.
REQ-036 MASK=0, pulse irq[0]. Required: PEND reads 8'h01 and int_n stays 1. Then write MASK=8'h01: int_n=0 within 2 cycles.
REQ-037 int_n=0, then write PEND=8'h01 (clear) before inta. Required: FSM returns to IDLE, int_n=1. A subsequent inta returns 8'h4E (spurious, VBASE=8'h40).
REQ-038 Write PEND=8'h04 in the same cycle as PEND[2] is set by irq. Required: PEND[2]=1.
REQ-039 Assert rst_n=0 during HOLD with inta held high. Required: dout_en=0 and int_n=1 immediately, and no ack occurs after release until inta falls and rises again.
